// File: rtl/matrix_denormalization.sv
`default_nettype none
// ============================================================================
// Module   : matrix_denormalization
// Purpose  : Maps a SIZE x SIZE matrix of unsigned normalized codes back to
//            signed values:  out = min_val + floor((q*range + 127) / 255),
//            range = max_val - min_val (0 when max_val < min_val).
//            One element is produced per clock in row-major order after a
//            start request; the inputs are captured on the accepting edge.
// Ports    : clk        - clock, all state on rising edge
//            reset      - asynchronous, active-high reset
//            start      - request a pass (ignored while a pass is running)
//            matrix_in  - unsigned normalized matrix  [SIZE][SIZE] x WIDTH_IN
//            min_val    - signed value mapped to code 0
//            max_val    - signed value mapped to code 255
//            busy       - high while elements are being computed
//            done       - high once all elements of the pass are valid
//            matrix_out - reconstructed signed matrix [SIZE][SIZE] x WIDTH_OUT
// Revision : 1.0 - initial release
// ============================================================================
module matrix_denormalization #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int SIZE      = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic        [WIDTH_IN-1:0]  matrix_in  [0:SIZE-1][0:SIZE-1],
  input  logic signed [WIDTH_OUT-1:0] min_val,
  input  logic signed [WIDTH_OUT-1:0] max_val,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIDTH_OUT-1:0] matrix_out [0:SIZE-1][0:SIZE-1]
);

  localparam int c_n_elem = SIZE * SIZE;
  localparam int c_idx_w  = (c_n_elem > 1) ? $clog2(c_n_elem) : 1;
  localparam int c_rc_w   = (SIZE > 1) ? $clog2(SIZE) : 1;
  // q*range needs WIDTH_IN + WIDTH_OUT bits; one more absorbs the +127.
  localparam int c_prod_w = WIDTH_IN + WIDTH_OUT + 1;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n_elem - 1);
  localparam logic [c_rc_w-1:0]  c_last_rc  = c_rc_w'(SIZE - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]                  r_state;
  logic [c_idx_w-1:0]          r_index;
  logic [c_rc_w-1:0]           r_row;
  logic [c_rc_w-1:0]           r_col;

  logic [WIDTH_IN-1:0]         r_snap [0:SIZE-1][0:SIZE-1];
  logic signed [WIDTH_OUT-1:0] r_min;
  logic [WIDTH_OUT:0]          r_range;

  logic                        w_accept;
  logic signed [WIDTH_OUT:0]   w_diff;
  logic [WIDTH_OUT:0]          w_range;
  logic [WIDTH_IN-1:0]         w_q;
  logic [c_prod_w-1:0]         w_num;
  logic [c_prod_w-1:0]         w_quot;
  logic signed [c_prod_w:0]    w_sum;
  logic signed [WIDTH_OUT-1:0] w_elem;

  // A start is only honoured outside CALC, so a running pass keeps its snapshot.
  assign w_accept = start && (r_state != c_st_calc);

  // The difference is taken one bit wider so it cannot overflow; its sign bit
  // then flags an inverted range, which collapses to zero.
  assign w_diff  = {max_val[WIDTH_OUT-1], max_val} - {min_val[WIDTH_OUT-1], min_val};
  assign w_range = w_diff[WIDTH_OUT] ? '0 : w_diff;

  // Per-element datapath. The quotient never exceeds range, so min + quotient
  // stays inside [min_val, max_val] and the final narrowing loses nothing.
  assign w_q    = r_snap[r_row][r_col];
  assign w_num  = c_prod_w'(w_q) * c_prod_w'(r_range) + c_prod_w'(127);
  assign w_quot = w_num / c_prod_w'(255);
  assign w_sum  = $signed({{(c_prod_w + 1 - WIDTH_OUT){r_min[WIDTH_OUT-1]}}, r_min})
                + $signed({1'b0, w_quot});
  assign w_elem = WIDTH_OUT'(w_sum);

  // Input snapshot; data-only registers, qualified by the accept strobe.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_snap  <= matrix_in;
      r_min   <= min_val;
      r_range <= w_range;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_index <= '0;
      r_row   <= '0;
      r_col   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          matrix_out[r][c] <= '0;
        end
      end
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (start) begin
            r_state <= c_st_calc;
            r_index <= '0;
            r_row   <= '0;
            r_col   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        c_st_calc: begin
          matrix_out[r_row][r_col] <= w_elem;
          if (r_index == c_last_idx) begin
            r_state <= c_st_done;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_index <= r_index + c_idx_w'(1);
            // Row/column counters track the index to avoid a divider.
            if (r_col == c_last_rc) begin
              r_col <= '0;
              r_row <= r_row + c_rc_w'(1);
            end else begin
              r_col <= r_col + c_rc_w'(1);
            end
          end
        end
        default: begin
          r_state <= c_st_idle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_denormalization.sv
`default_nettype none
module tb_matrix_denormalization;
  localparam int WI = 8;
  localparam int WO = 16;
  localparam int SZ = 10;
  localparam int N  = SZ * SZ;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic        [WI-1:0] matrix_in  [0:SZ-1][0:SZ-1];
  logic signed [WO-1:0] min_val;
  logic signed [WO-1:0] max_val;
  logic                 busy;
  logic                 done;
  logic signed [WO-1:0] matrix_out [0:SZ-1][0:SZ-1];

  matrix_denormalization #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .SIZE(SZ)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .matrix_in  (matrix_in),
    .min_val    (min_val),
    .max_val    (max_val),
    .busy       (busy),
    .done       (done),
    .matrix_out (matrix_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int exp_q[$];        // per pass: start edge number, then N expected elements
  int last_exp[N];
  int old_exp[N];
  logic done_q = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: out = min + floor((q*range + 127)/255), range clamped at 0.
  function automatic int ref_elem(input int q, input int mn, input int mx);
    longint rng;
    rng = (mx < mn) ? 64'sd0 : (longint'(mx) - longint'(mn));
    return int'(longint'(mn) + (longint'(q) * rng + 64'sd127) / 64'sd255);
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor / scoreboard: on every rising of done, pop one pass and compare.
  always @(negedge clk) begin
    check("busy_and_done_exclusive", int'(busy && done), 0);
    if (done && !done_q) begin
      if (exp_q.size() < N + 1) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got queue depth %0d expected %0d", exp_q.size(), N + 1);
      end else begin
        int s;
        s = exp_q.pop_front();
        check("done_latency_edges", edge_cnt - s + 1, N + 1);
        for (int k = 0; k < N; k++) begin
          int e;
          e = exp_q.pop_front();
          if (int'(matrix_out[k / SZ][k % SZ]) != e) begin
            $display("FAIL elem[%0d][%0d]: got %0d expected %0d", k / SZ, k % SZ,
                     int'(matrix_out[k / SZ][k % SZ]), e);
            n_err++;
          end
          n_vec++;
        end
      end
    end
    done_q = done;
  end

  task automatic randomize_inputs();
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        matrix_in[r][c] = WI'($urandom);
    min_val = WO'($urandom);
    max_val = WO'($urandom);
  endtask

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(edge_cnt + 1);
    for (int k = 0; k < N; k++) begin
      int e;
      e = ref_elem(int'(matrix_in[k / SZ][k % SZ]), int'(min_val), int'(max_val));
      exp_q.push_back(e);
      last_exp[k] = e;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout: got done=%0d expected 1 within 200 cycles", done);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    int nz;
    nz = 0;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        if (matrix_out[r][c] != '0) nz++;
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_nonzero_outputs"}, nz, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    randomize_inputs();
    #1;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Mixed-sign range with hand-computed anchor points.
    randomize_inputs();
    min_val = -16'sd575;
    max_val = 16'sd3300;
    matrix_in[0][0] = 8'd255;
    matrix_in[0][1] = 8'd0;
    matrix_in[0][2] = 8'd136;
    matrix_in[9][4] = 8'd0;
    start_pass();
    wait_done();
    check("anchor_0_0", int'(matrix_out[0][0]), 3300);
    check("anchor_0_1", int'(matrix_out[0][1]), -575);
    check("anchor_0_2", int'(matrix_out[0][2]), 1492);
    check("anchor_9_4", int'(matrix_out[9][4]), -575);

    // Identity mapping with cycle-by-cycle busy/done/element timing.
    min_val = 16'sd0;
    max_val = 16'sd255;
    for (int k = 0; k < N; k++) matrix_in[k / SZ][k % SZ] = WI'(k);
    old_exp = last_exp;
    start_pass();
    for (int i = 0; i <= N; i++) begin
      check("timing_busy", int'(busy), int'(i < N));
      check("timing_done", int'(done), int'(i == N));
      if (i >= 1) check("timing_elem_written", int'(matrix_out[(i - 1) / SZ][(i - 1) % SZ]), i - 1);
      if (i < N)  check("timing_elem_retained", int'(matrix_out[i / SZ][i % SZ]), old_exp[i]);
      if (i < N) @(negedge clk);
    end
    wait_done();

    // Inverted range: every element collapses to min_val.
    randomize_inputs();
    min_val = 16'sd100;
    max_val = 16'sd50;
    start_pass();
    wait_done();
    check("inverted_corner", int'(matrix_out[9][9]), 100);

    // Full-scale range, largest possible product.
    randomize_inputs();
    min_val = -16'sd32768;
    max_val = 16'sd32767;
    matrix_in[0][0] = 8'd0;
    matrix_in[0][1] = 8'd128;
    matrix_in[0][2] = 8'd255;
    start_pass();
    wait_done();
    check("full_scale_code0", int'(matrix_out[0][0]), -32768);
    // -32768 + floor((128*65535 + 127)/255) = -32768 + 32896
    check("full_scale_code128", int'(matrix_out[0][1]), 128);
    check("full_scale_code255", int'(matrix_out[0][2]), 32767);

    // Random passes, back to back from DONE.
    for (int p = 0; p < 6; p++) begin
      randomize_inputs();
      start_pass();
      wait_done();
    end

    // A start during CALC with changed inputs must be ignored.
    randomize_inputs();
    start_pass();
    repeat (48) @(negedge clk);
    randomize_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored_busy", int'(busy), 1);
    wait_done();

    // Reset in mid-pass aborts it; the next pass runs in full.
    randomize_inputs();
    start_pass();
    repeat (39) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_reset_state("midpass_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("after_reset_idle_done", int'(done), 0);
    randomize_inputs();
    start_pass();
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
